pr_request_queue: RTL and testbench
===================================

Name: pr_request_queue

Overview:
- Parametrised partial-reconfiguration request queue between the RCA config path (grid_slot / ou_id requests) and the PR/ICAP controller.
- Buffers up to DEPTH pending reconfigurations and merges duplicate requests for the same grid slot.
- Serialises issue to the controller with a valid/ready handshake, then waits for completion.
- Publishes per-slot busy status so decode can stall RCA use instructions that target slots still being reconfigured.

Parameters:
- DEPTH, 4, queue entries (power of two, >=2)
- NUM_SLOTS, 16, grid slots (GRID_NUM_COLS*GRID_NUM_ROWS)
- NUM_OUS, 8, number of operation-unit bitstreams
- SLOT_W, $clog2(NUM_SLOTS), slot index width
- OU_W, $clog2(NUM_OUS), OU id width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  new PR request
- req_slot  in  SLOT_W  target grid slot
- req_ou  in  OU_W  OU to load
- req_ready  out  1  request accepted this cycle when req_valid
- flush  in  1  discard all queued, not-yet-issued entries
- pr_valid  out  1  request offered to PR controller
- pr_slot  out  SLOT_W  offered slot
- pr_ou  out  OU_W  offered OU
- pr_ready  in  1  controller accepts offer
- pr_done  in  1  controller finished current reconfiguration (1-cycle pulse)
- pr_complete  out  1  1-cycle pulse when a reconfiguration finishes
- pr_complete_slot  out  SLOT_W  slot that just finished
- slot_busy  out  NUM_SLOTS  bit i = slot i queued or being reconfigured
- count  out  $clog2(DEPTH+1)  queued entries, in-progress entry excluded

Behaviour:
- Reset values: all outputs 0, queue empty, FSM in IDLE.
- Reset mid-operation abandons any in-progress entry without a pr_complete pulse.
- Storage: circular FIFO with head/tail pointers; count is registered.
- Merge rule:
  - A request hits when its slot equals a queued entry's slot, excluding the head entry while the FSM is in ISSUE.
  - On a hit, that entry's ou is overwritten in place; count is unchanged.
  - At most one entry per slot exists, so at most one hit.
- req_ready = !flush && (merge_hit || count<DEPTH). It is combinational from registered state plus the req inputs.
- When full, a pop in the same cycle does not free space for a non-merging push.
- A request for the slot currently in WAIT_DONE does not merge; it enqueues as a new entry.
- Acceptance occurs on the edge where req_valid && req_ready. The entry is visible from the next cycle.
- FSM:
  - IDLE: if count!=0, go to ISSUE next edge.
  - ISSUE: pr_valid=1, with pr_slot/pr_ou taken from the head. On pr_valid&&pr_ready, pop the head into the in-progress register and go to WAIT_DONE.
  - WAIT_DONE: pr_valid=0. On pr_done, pulse pr_complete with the in-progress slot on the next cycle, clear the in-progress entry, and go to IDLE.
- pr_done outside WAIT_DONE is ignored.
- Issue latency: a request accepted at edge N into an empty, IDLE queue gives pr_valid=1 in the cycle after edge N+1.
- While pr_valid=1, pr_slot and pr_ou hold stable until the handshake, because head merges are excluded.
- Flush:
  - Empties the queue (count=0) on the next edge.
  - In ISSUE, a flush without a same-cycle handshake returns the FSM to IDLE and deasserts pr_valid. This is the only permitted valid withdrawal.
  - A flush coinciding with a handshake lets the handshake complete: the entry goes to WAIT_DONE and the rest is flushed.
  - A flush never affects an entry already in WAIT_DONE.
  - A request in the flush cycle is refused (req_ready=0).
- slot_busy: OR of one-hot decodes of all valid queued entries plus the in-progress entry. It is registered and updates the cycle after each push, merge, pop, completion or flush.
- Simultaneous push and pop with count<DEPTH: count is unchanged and both pointers advance.

Test Plan:
- Reset, then req (slot 3, ou 2) with pr_ready=1 → pr_valid in the cycle after edge N+1 with slot 3 / ou 2. Then pulse pr_done → pr_complete=1, pr_complete_slot=3, slot_busy all 0 afterwards.
- Hold pr_ready=0 and enqueue slots 1, 2, 3, 4 → count=4; a new slot 5 sees req_ready=0. Req slot 2 / ou 7 → req_ready=1, count stays 4, and that entry issues later with ou 7.
- Head slot 1 in ISSUE, req slot 1 / ou 5 → no merge, count increments. Slot 1 is issued twice: first with the original ou, then with ou 5.
- Queue 3 entries, first in WAIT_DONE, assert flush → count=0, slot_busy shows only the in-progress slot. pr_done completes it normally.
- flush in the same cycle as pr_valid&&pr_ready → FSM enters WAIT_DONE with that entry, other entries discarded, request in that cycle refused.
- Assert rst asynchronously mid-WAIT_DONE → all outputs 0 immediately. A later pr_done produces no pr_complete.

Source files
------------

// File: rtl/pr_request_queue.sv
// pr_request_queue: merging FIFO of partial-reconfiguration requests in front of the PR/ICAP controller.
// Tracks queued and in-flight slots so decode can stall uses of slots that are still being rewritten.
module pr_request_queue #(
  parameter int DEPTH     = 4,
  parameter int NUM_SLOTS = 16,
  parameter int NUM_OUS   = 8,
  parameter int SLOT_W    = $clog2(NUM_SLOTS),
  parameter int OU_W      = $clog2(NUM_OUS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [SLOT_W-1:0]          req_slot,
  input  logic [OU_W-1:0]            req_ou,
  output logic                       req_ready,
  input  logic                       flush,
  output logic                       pr_valid,
  output logic [SLOT_W-1:0]          pr_slot,
  output logic [OU_W-1:0]            pr_ou,
  input  logic                       pr_ready,
  input  logic                       pr_done,
  output logic                       pr_complete,
  output logic [SLOT_W-1:0]          pr_complete_slot,
  output logic [NUM_SLOTS-1:0]       slot_busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q [DEPTH];
  logic [SLOT_W-1:0]     slot_d [DEPTH];
  logic [OU_W-1:0]       ou_q   [DEPTH];
  logic [OU_W-1:0]       ou_d   [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ip_valid_q, ip_valid_d;
  logic [SLOT_W-1:0]     ip_slot_q, ip_slot_d;
  logic                  cmp_q, cmp_d;
  logic [SLOT_W-1:0]     cmp_slot_q, cmp_slot_d;
  logic [NUM_SLOTS-1:0]  busy_q, busy_d;

  logic [DEPTH-1:0]      hit_vec_s;
  logic                  hit_s;
  logic [PTR_W-1:0]      hit_idx_s;
  logic                  accept_s;
  logic                  push_new_s;
  logic                  handshake_s;

  function automatic logic entry_live(input logic [PTR_W-1:0] idx,
                                      input logic [PTR_W-1:0] hd,
                                      input logic [CNT_W-1:0] cnt);
    logic [PTR_W-1:0] off;
    off = idx - hd;
    return (CNT_W'(off) < cnt);
  endfunction

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    return NUM_SLOTS'(1) << s;
  endfunction

  // Merge lookup: the head being offered is frozen, so it never takes a merge.
  always_comb begin
    hit_vec_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live(PTR_W'(i), head_q, count_q) && (slot_q[i] == req_slot) &&
          !((state_q == ST_ISSUE) && (PTR_W'(i) == head_q))) begin
        hit_vec_s[i] = 1'b1;
      end else begin
        hit_vec_s[i] = 1'b0;
      end
    end
  end

  always_comb begin
    hit_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_idx_s = hit_vec_s[i] ? PTR_W'(i) : hit_idx_s;
    end
  end

  assign hit_s       = |hit_vec_s;
  assign req_ready   = !rst && !flush && (hit_s || (count_q < CNT_W'(DEPTH)));
  assign accept_s    = req_valid && req_ready;
  assign push_new_s  = accept_s && !hit_s;
  assign handshake_s = (state_q == ST_ISSUE) && pr_ready;

  // Queue contents, pointers, in-progress entry and issue FSM next state.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    ou_d       = ou_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ip_valid_d = ip_valid_q;
    ip_slot_d  = ip_slot_q;
    cmp_d      = 1'b0;
    cmp_slot_d = cmp_slot_q;

    if (accept_s && hit_s) begin
      ou_d[hit_idx_s] = req_ou;
    end else if (push_new_s) begin
      slot_d[tail_q] = req_slot;
      ou_d[tail_q]   = req_ou;
      tail_d         = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end

    if (handshake_s) begin
      head_d     = head_q + PTR_W'(1);
      ip_valid_d = 1'b1;
      ip_slot_d  = slot_q[head_q];
    end else begin
      head_d = head_q;
    end

    // A refused request means tail_q is already the post-flush tail.
    if (flush) begin
      count_d = '0;
      head_d  = tail_q;
    end else begin
      count_d = count_q + CNT_W'(push_new_s) - CNT_W'(handshake_s);
    end

    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && !flush) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (handshake_s) begin
          state_d = ST_WAIT;
        end else if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (pr_done) begin
          cmp_d      = 1'b1;
          cmp_slot_d = ip_slot_q;
          ip_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Busy map reflects the post-edge queue so it lands together with the entry change.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live(PTR_W'(i), head_d, count_d)) begin
        busy_d = busy_d | slot_onehot(slot_d[i]);
      end else begin
        busy_d = busy_d;
      end
    end
    if (ip_valid_d) begin
      busy_d = busy_d | slot_onehot(ip_slot_d);
    end else begin
      busy_d = busy_d;
    end
  end

  // State registers; reset drops any in-flight entry silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
        ou_q[i]   <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ip_valid_q <= 1'b0;
      ip_slot_q  <= '0;
      cmp_q      <= 1'b0;
      cmp_slot_q <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
        ou_q[i]   <= ou_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ip_valid_q <= ip_valid_d;
      ip_slot_q  <= ip_slot_d;
      cmp_q      <= cmp_d;
      cmp_slot_q <= cmp_slot_d;
      busy_q     <= busy_d;
    end
  end

  assign pr_valid         = (state_q == ST_ISSUE);
  assign pr_slot          = pr_valid ? slot_q[head_q] : '0;
  assign pr_ou            = pr_valid ? ou_q[head_q] : '0;
  assign pr_complete      = cmp_q;
  assign pr_complete_slot = cmp_slot_q;
  assign slot_busy        = busy_q;
  assign count            = count_q;

endmodule

// File: tb/tb_pr_request_queue.sv
// Bench for pr_request_queue: queue-level reference model checked every cycle plus directed scenarios.
module tb_pr_request_queue;

  localparam int DEPTH     = 4;
  localparam int NUM_SLOTS = 16;
  localparam int NUM_OUS   = 8;
  localparam int SLOT_W    = 4;
  localparam int OU_W      = 3;
  localparam int CNT_W     = 3;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [OU_W-1:0]   ou;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic [SLOT_W-1:0]    req_slot = '0;
  logic [OU_W-1:0]      req_ou = '0;
  logic                 flush = 1'b0;
  logic                 pr_ready = 1'b0;
  logic                 pr_done = 1'b0;
  logic                 req_ready;
  logic                 pr_valid;
  logic [SLOT_W-1:0]    pr_slot;
  logic [OU_W-1:0]      pr_ou;
  logic                 pr_complete;
  logic [SLOT_W-1:0]    pr_complete_slot;
  logic [NUM_SLOTS-1:0] slot_busy;
  logic [CNT_W-1:0]     count;

  int checks = 0;
  int errors = 0;

  // Reference model: pending list, phase (0 idle, 1 offering, 2 awaiting done), in-flight slot.
  ent_t              mq[$];
  int                m_st = 0;
  logic              m_ip_valid = 1'b0;
  logic [SLOT_W-1:0] m_ip_slot = '0;
  logic              m_cmp = 1'b0;
  logic [SLOT_W-1:0] m_cmp_slot = '0;
  ent_t              dut_issued[$];

  pr_request_queue #(
    .DEPTH(DEPTH), .NUM_SLOTS(NUM_SLOTS), .NUM_OUS(NUM_OUS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_slot(req_slot), .req_ou(req_ou), .req_ready(req_ready),
    .flush(flush),
    .pr_valid(pr_valid), .pr_slot(pr_slot), .pr_ou(pr_ou), .pr_ready(pr_ready),
    .pr_done(pr_done), .pr_complete(pr_complete), .pr_complete_slot(pr_complete_slot),
    .slot_busy(slot_busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic int m_hit();
    int h;
    h = -1;
    for (int j = 0; j < mq.size(); j++) begin
      if (!((m_st == 1) && (j == 0)) && (mq[j].slot == req_slot)) h = j;
    end
    return h;
  endfunction

  function automatic logic m_ready();
    return !rst && !flush && ((m_hit() >= 0) || (mq.size() < DEPTH));
  endfunction

  function automatic logic [NUM_SLOTS-1:0] m_busy();
    logic [NUM_SLOTS-1:0] b;
    b = '0;
    for (int j = 0; j < mq.size(); j++) b[mq[j].slot] = 1'b1;
    if (m_ip_valid) b[m_ip_slot] = 1'b1;
    return b;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_st = 0;
    m_ip_valid = 1'b0;
    m_ip_slot = '0;
    m_cmp = 1'b0;
    m_cmp_slot = '0;
  endtask

  task automatic m_step();
    int   h;
    int   n0;
    logic acc;
    logic hs;
    ent_t e;
    h   = m_hit();
    acc = req_valid && m_ready();
    hs  = (m_st == 1) && pr_ready;
    n0  = mq.size();
    m_cmp = 1'b0;
    if (acc && (h >= 0)) begin
      e = mq[h];
      e.ou = req_ou;
      mq[h] = e;
    end else if (acc) begin
      e = {req_slot, req_ou};
      mq.push_back(e);
    end
    if (hs) begin
      m_ip_valid = 1'b1;
      m_ip_slot  = mq[0].slot;
      void'(mq.pop_front());
    end
    if (flush) mq.delete();
    case (m_st)
      0: if ((n0 != 0) && !flush) m_st = 1;
      1: begin
        if (hs) m_st = 2;
        else if (flush) m_st = 0;
      end
      2: if (pr_done) begin
        m_cmp = 1'b1;
        m_cmp_slot = m_ip_slot;
        m_ip_valid = 1'b0;
        m_st = 0;
      end
      default: m_st = 0;
    endcase
  endtask

  // Per-cycle compare against the model, then advance it with the inputs the next edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      chk("req_ready", req_ready, m_ready());
      chk("pr_valid", pr_valid, m_st == 1);
      if (m_st == 1) begin
        chk("pr_slot", pr_slot, mq[0].slot);
        chk("pr_ou", pr_ou, mq[0].ou);
      end
      chk("count", count, mq.size());
      chk("slot_busy", slot_busy, m_busy());
      chk("pr_complete", pr_complete, m_cmp);
      if (m_cmp) chk("pr_complete_slot", pr_complete_slot, m_cmp_slot);
      if (!rst) begin
        if (pr_valid && pr_ready) dut_issued.push_back({pr_slot, pr_ou});
        m_step();
      end
    end
  end

  task automatic req(input logic [SLOT_W-1:0] s, input logic [OU_W-1:0] o);
    req_valid = 1'b1;
    req_slot  = s;
    req_ou    = o;
  endtask

  task automatic drain();
    int n;
    n = 0;
    pr_ready = 1'b1;
    while (((mq.size() != 0) || (m_st != 0) || m_ip_valid) && (n < 80)) begin
      pr_done = (m_st == 2);
      cyc();
      n++;
    end
    pr_done  = 1'b0;
    pr_ready = 1'b0;
    chk("drain_bound", n < 80, 1'b1);
    cyc();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (2) cyc();
    chk("rst_count", count, 3'd0);
    chk("rst_busy", slot_busy, 16'h0000);
    chk("rst_pr_valid", pr_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    cyc();

    // Basic issue latency and completion.
    pr_ready = 1'b1;
    req(4'd3, 3'd2);
    cyc();
    req_valid = 1'b0;
    chk("t1_not_yet_valid", pr_valid, 1'b0);
    chk("t1_busy_q", slot_busy, 16'h0008);
    cyc();
    chk("t1_valid", pr_valid, 1'b1);
    chk("t1_slot", pr_slot, 4'd3);
    chk("t1_ou", pr_ou, 3'd2);
    cyc();
    chk("t1_wait_valid", pr_valid, 1'b0);
    chk("t1_busy_ip", slot_busy, 16'h0008);
    pr_done = 1'b1;
    cyc();
    pr_done = 1'b0;
    pr_ready = 1'b0;
    chk("t1_complete", pr_complete, 1'b1);
    chk("t1_complete_slot", pr_complete_slot, 4'd3);
    chk("t1_busy_clear", slot_busy, 16'h0000);
    cyc();
    chk("t1_complete_pulse", pr_complete, 1'b0);

    // Fill to DEPTH, refuse new slot, merge into non-head entry.
    base = dut_issued.size();
    for (int s = 1; s <= 4; s++) begin
      req(4'(s), 3'd1);
      cyc();
    end
    chk("t2_full_count", count, 3'd4);
    req(4'd5, 3'd1);
    #1;
    chk("t2_full_refuse", req_ready, 1'b0);
    req(4'd2, 3'd7);
    #1;
    chk("t2_merge_ready", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    chk("t2_merge_count", count, 3'd4);
    drain();
    chk("t2_issued_n", dut_issued.size(), base + 4);
    if (dut_issued.size() >= base + 2) chk("t2_merged_ou", dut_issued[base+1], {4'd2, 3'd7});

    // Same slot as the head in ISSUE enqueues rather than merging.
    base = dut_issued.size();
    req(4'd1, 3'd3);
    cyc();
    req_valid = 1'b0;
    cyc();
    req(4'd1, 3'd5);
    #1;
    chk("t3_ready", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    chk("t3_count", count, 3'd2);
    drain();
    chk("t3_issued_n", dut_issued.size(), base + 2);
    if (dut_issued.size() >= base + 2) begin
      chk("t3_first", dut_issued[base], {4'd1, 3'd3});
      chk("t3_second", dut_issued[base+1], {4'd1, 3'd5});
    end

    // Flush while one entry is in WAIT_DONE.
    req(4'd6, 3'd0); cyc();
    req(4'd7, 3'd0); cyc();
    req(4'd8, 3'd0); cyc();
    req_valid = 1'b0;
    pr_ready = 1'b1;
    cyc();
    pr_ready = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t4_count", count, 3'd0);
    chk("t4_busy", slot_busy, 16'h0040);
    pr_done = 1'b1;
    cyc();
    pr_done = 1'b0;
    chk("t4_complete", pr_complete, 1'b1);
    chk("t4_complete_slot", pr_complete_slot, 4'd6);
    cyc();

    // Flush coinciding with the handshake.
    req(4'd9, 3'd4); cyc();
    req(4'd10, 3'd4); cyc();
    req(4'd11, 3'd4); cyc();
    req(4'd12, 3'd4);
    flush = 1'b1;
    pr_ready = 1'b1;
    #1;
    chk("t5_refuse", req_ready, 1'b0);
    cyc();
    req_valid = 1'b0;
    flush = 1'b0;
    pr_ready = 1'b0;
    chk("t5_valid", pr_valid, 1'b0);
    chk("t5_count", count, 3'd0);
    chk("t5_busy", slot_busy, 16'h0200);
    pr_done = 1'b1;
    cyc();
    pr_done = 1'b0;
    chk("t5_complete_slot", pr_complete_slot, 4'd9);
    cyc();

    // Asynchronous reset during WAIT_DONE.
    pr_ready = 1'b1;
    req(4'd13, 3'd1); cyc();
    req(4'd14, 3'd2); cyc();
    req_valid = 1'b0;
    cyc();
    pr_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_count", count, 3'd0);
    chk("t6_busy", slot_busy, 16'h0000);
    chk("t6_valid", pr_valid, 1'b0);
    chk("t6_ready", req_ready, 1'b0);
    cyc();
    rst = 1'b0;
    pr_done = 1'b1;
    cyc();
    pr_done = 1'b0;
    cyc();
    chk("t6_no_complete", pr_complete, 1'b0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
